// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
// Imported by the SRAM slave RTL and its bench.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Wide enough for the largest supported read wait count (7).
  localparam int WAIT_W = 3;

endpackage

// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite slave-side bus bundle for the wait-state SRAM.
// HREADY comes from the interconnect, so it sits on the master side.
interface ahb_sram_ws_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              HSEL;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [AWIDTH-1:0] HADDR;
  logic [DWIDTH-1:0] HWDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DWIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/sram_bytelane_array.sv
// Behavioural byte-enabled synchronous-read RAM (read-old-data on collision).
// Kept port-compatible with a foundry macro so it can be swapped out.
module sram_bytelane_array #(
  parameter int    DWIDTH    = 32,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH),
  localparam int   NB        = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     wstrb,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [NB-1:0][7:0] mem [DEPTH];

  // NOTE: no reset on the storage or its read register -- a RAM macro has no
  // reset path, and clearing thousands of flops would defeat the purpose.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[waddr][i] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with configurable read wait states, two-cycle ERROR
// responses for illegal accesses and read-after-write byte forwarding.
module ahb_sram_ws
  import ahb_pkg::*;
#(
  parameter int    AWIDTH    = 12,
  parameter int    DWIDTH    = 32,
  parameter int    RD_WAIT   = 0,
  parameter string INIT_FILE = ""
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_sram_ws_if.slave      bus
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IW     = AWIDTH - LSB;
  localparam int DEPTH  = 1 << IW;
  localparam logic [WAIT_W-1:0] RD_WAIT_L = WAIT_W'(RD_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [NBYTES-1:0] strb_q, strb_a;
  logic [IW-1:0]     idx_q, idx_a;
  logic [NBYTES-1:0] fwd_mask_q;
  logic [DWIDTH-1:0] fwd_data_q;
  logic [DWIDTH-1:0] hrdata_q;
  logic [DWIDTH-1:0] mem_rdata;
  logic [DWIDTH-1:0] rd_word;
  logic [LSB-1:0]    off;
  logic [7:0]        span;
  logic              accept, take, illegal, ready;
  logic              rd_issue, wr_commit, rd_done;
  hresp_e            resp;

  // ---------------- address phase decode ----------------
  assign idx_a  = bus.HADDR[AWIDTH-1:LSB];
  assign accept = bus.HSEL && bus.HREADY &&
                  (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

  // Strobes cover `span` lanes starting at the byte offset; oversize or
  // misaligned requests are flagged and never reach the array.
  always_comb begin
    off     = bus.HADDR[LSB-1:0];
    span    = 8'd1 << bus.HSIZE;
    illegal = (bus.HSIZE > 3'(LSB)) || ((8'(off) & (span - 8'd1)) != 8'd0);
    strb_a  = '0;
    for (int i = 0; i < NBYTES; i++)
      strb_a[i] = (i >= int'(off)) && (i < int'(off) + int'(span));
  end

  // ---------------- data phase status ----------------
  assign ready = (state_q == ST_RD) ? (cnt_q == '0) : (state_q != ST_ERR1);
  assign resp  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  assign take      = ready && accept;
  assign rd_issue  = take && !illegal && !bus.HWRITE;
  assign wr_commit = (state_q == ST_WR);
  assign rd_done   = (state_q == ST_RD) && (cnt_q == '0);

  // ---------------- state machine ----------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_WR, ST_ERR2: ;
      ST_RD:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (ready) begin
      if (take) begin
        if (illegal)          state_d = ST_ERR1;
        else if (bus.HWRITE)  state_d = ST_WR;
        else begin
          state_d = ST_RD;
          cnt_d   = RD_WAIT_L;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      strb_q     <= '0;
      idx_q      <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take && !illegal) begin
        strb_q <= strb_a;
        idx_q  <= idx_a;
      end
      // The array returns pre-write data when a read collides with the
      // committing write, so remember which lanes to patch from HWDATA.
      if (rd_issue) begin
        fwd_mask_q <= (wr_commit && idx_q == idx_a) ? strb_q : '0;
        fwd_data_q <= bus.HWDATA;
      end
      if (rd_done) hrdata_q <= rd_word;
    end
  end

  // ---------------- read data path ----------------
  always_comb begin
    rd_word = mem_rdata;
    for (int i = 0; i < NBYTES; i++)
      if (fwd_mask_q[i]) rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = rd_done ? rd_word : hrdata_q;

  sram_bytelane_array #(
    .DWIDTH    (DWIDTH),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (HCLK),
    .we    (wr_commit),
    .wstrb (strb_q),
    .waddr (idx_q),
    .wdata (bus.HWDATA),
    .re    (rd_issue),
    .raddr (idx_a),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Bench for ahb_sram_ws: a zero-wait and a three-wait instance driven by a
// pipelined master replaying a vector table through an expectation queue.
module tb_ahb_sram_ws;
  import ahb_pkg::*;

  typedef struct {
    string       name;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          waits;
    logic [31:0] rdata;
  } vec_t;

  localparam int RUN_LIMIT = 400;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel, hwrite, use3;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [11:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;
  vec_t        vt[$];

  always #5 HCLK = ~HCLK;

  ahb_sram_ws_if #(.AWIDTH(12), .DWIDTH(32)) bus0 ();
  ahb_sram_ws_if #(.AWIDTH(12), .DWIDTH(32)) bus3 ();

  assign bus0.HSEL   = hsel && !use3;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus0.HTRANS = htrans;
  assign bus0.HSIZE  = hsize;
  assign bus0.HWRITE = hwrite;
  assign bus0.HADDR  = haddr;
  assign bus0.HWDATA = hwdata;

  assign bus3.HSEL   = hsel && use3;
  assign bus3.HREADY = bus3.HREADYOUT;
  assign bus3.HTRANS = htrans;
  assign bus3.HSIZE  = hsize;
  assign bus3.HWRITE = hwrite;
  assign bus3.HADDR  = haddr;
  assign bus3.HWDATA = hwdata;

  ahb_sram_ws #(.AWIDTH(12), .DWIDTH(32), .RD_WAIT(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0)
  );
  ahb_sram_ws #(.AWIDTH(12), .DWIDTH(32), .RD_WAIT(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_ready();
    return use3 ? bus3.HREADYOUT : bus0.HREADYOUT;
  endfunction

  function automatic logic cur_resp();
    return use3 ? bus3.HRESP : bus0.HRESP;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return use3 ? bus3.HRDATA : bus0.HRDATA;
  endfunction

  function automatic void add(input string name, input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic err, input int waits,
                              input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.err = err; v.waits = waits; v.rdata = rdata;
    vt.push_back(v);
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = '0;
  endtask

  // Replays vt[first..last-1] as a pipelined master on the selected slave.
  task automatic run(input int first, input int last);
    vec_t sb[$];
    vec_t dp;
    bit   dp_v = 1'b0;
    int   dp_w = 0;
    int   ai   = first;
    int   cyc  = 0;
    logic rdy;
    while ((ai < last || dp_v || sb.size() != 0) && cyc < RUN_LIMIT) begin
      if (ai < last) begin
        hsel = 1'b1; htrans = vt[ai].trans; hwrite = vt[ai].wr;
        hsize = vt[ai].size; haddr = vt[ai].addr;
      end else begin
        drive_idle();
      end
      hwdata = dp_v ? dp.wdata : 32'h0;
      @(negedge HCLK);
      rdy = cur_ready();
      if (dp_v) begin
        check({dp.name, " hresp"}, 32'(cur_resp()), 32'(dp.err));
        if (!rdy) dp_w++;
        else begin
          check({dp.name, " waits"}, 32'(dp_w), 32'(dp.waits));
          if (dp.trans[1] && !dp.wr && !dp.err) begin
            check({dp.name, " hrdata"}, cur_rdata(), dp.rdata);
            last_rd[use3] = dp.rdata;
          end else begin
            check({dp.name, " hold"}, cur_rdata(), last_rd[use3]);
          end
          dp_v = 1'b0;
        end
      end
      if (rdy && ai < last) begin
        sb.push_back(vt[ai]);
        ai++;
      end
      @(posedge HCLK); #1;
      if (!dp_v && sb.size() != 0) begin
        dp   = sb.pop_front();
        dp_v = 1'b1;
        dp_w = 0;
      end
      cyc++;
    end
    if (cyc >= RUN_LIMIT) begin
      checks++; errors++;
      $display("FAIL run timeout: %0d cycles, vectors %0d..%0d", cyc, first, last - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_pre3, b_main, b_d3, b_post, b_end;
    HRESETn = 1'b0; use3 = 1'b0; hwdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    drive_idle();

    // zero-wait slave: preload
    add("pre 010", HTRANS_NONSEQ, 1, HSIZE_WORD, 12'h010, 32'hDEADBEEF, 0, 0, 0);
    add("pre 040", HTRANS_NONSEQ, 1, HSIZE_WORD, 12'h040, 32'h11223344, 0, 0, 0);
    add("pre 004", HTRANS_NONSEQ, 1, HSIZE_WORD, 12'h004, 32'h55667788, 0, 0, 0);
    add("pre ffc", HTRANS_NONSEQ, 1, HSIZE_WORD, 12'hFFC, 32'hCAFEF00D, 0, 0, 0);
    add("pre idle", HTRANS_IDLE, 0, HSIZE_WORD, 12'h000, 0, 0, 0, 0);
    b_pre3 = vt.size();
    add("pre3 020", HTRANS_NONSEQ, 1, HSIZE_WORD, 12'h020, 32'h0A0B0C0D, 0, 0, 0);
    add("pre3 idle", HTRANS_IDLE, 0, HSIZE_WORD, 12'h000, 0, 0, 0, 0);
    // zero-wait slave: main traffic
    b_main = vt.size();
    add("rd 010",      HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h010, 0, 0, 0, 32'hDEADBEEF);
    add("wb 041",      HTRANS_NONSEQ, 1, HSIZE_BYTE,  12'h041, 32'h0000AA00, 0, 0, 0);
    add("rd fwd 040",  HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h040, 0, 0, 0, 32'h1122AA44);
    add("rd 040",      HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h040, 0, 0, 0, 32'h1122AA44);
    add("err ww 042",  HTRANS_NONSEQ, 1, HSIZE_WORD,  12'h042, 32'h99999999, 1, 1, 0);
    add("idle a",      HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    add("rd post err", HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h040, 0, 0, 0, 32'h1122AA44);
    add("wh 006",      HTRANS_NONSEQ, 1, HSIZE_HALF,  12'h006, 32'hBEEF0000, 0, 0, 0);
    add("rd fwd 004",  HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h004, 0, 0, 0, 32'hBEEF7788);
    add("err size3",   HTRANS_NONSEQ, 0, HSIZE_DWORD, 12'h008, 0, 1, 1, 0);
    add("idle b",      HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    add("err wh 001",  HTRANS_NONSEQ, 1, HSIZE_HALF,  12'h001, 32'h77777777, 1, 1, 0);
    add("idle c",      HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    add("ww 010",      HTRANS_NONSEQ, 1, HSIZE_WORD,  12'h010, 32'h01020304, 0, 0, 0);
    add("rd nofwd 004",HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h004, 0, 0, 0, 32'hBEEF7788);
    add("rd 010 new",  HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h010, 0, 0, 0, 32'h01020304);
    add("rb 043",      HTRANS_NONSEQ, 0, HSIZE_BYTE,  12'h043, 0, 0, 0, 32'h1122AA44);
    add("busy",        HTRANS_BUSY,   0, HSIZE_WORD,  12'h044, 0, 0, 0, 0);
    add("rd seq 040",  HTRANS_SEQ,    0, HSIZE_WORD,  12'h040, 0, 0, 0, 32'h1122AA44);
    add("rd top ffc",  HTRANS_NONSEQ, 0, HSIZE_WORD,  12'hFFC, 0, 0, 0, 32'hCAFEF00D);
    add("idle d",      HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    // three-wait slave
    b_d3 = vt.size();
    add("w3 rd 020",   HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h020, 0, 0, 3, 32'h0A0B0C0D);
    add("w3 rd b2b",   HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h020, 0, 0, 3, 32'h0A0B0C0D);
    add("w3 wb 023",   HTRANS_NONSEQ, 1, HSIZE_BYTE,  12'h023, 32'hFF000000, 0, 0, 0);
    add("w3 rd fwd",   HTRANS_NONSEQ, 0, HSIZE_WORD,  12'h020, 0, 0, 3, 32'hFF0B0C0D);
    add("w3 err 022",  HTRANS_NONSEQ, 1, HSIZE_WORD,  12'h022, 32'h12345678, 1, 1, 0);
    add("w3 idle",     HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    b_post = vt.size();
    add("w3 rd after rst", HTRANS_NONSEQ, 0, HSIZE_WORD, 12'h020, 0, 0, 3, 32'hFF0B0C0D);
    add("w3 idle end", HTRANS_IDLE,   0, HSIZE_WORD,  12'h000, 0, 0, 0, 0);
    b_end = vt.size();

    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    use3 = 1'b0; run(0, b_pre3);
    use3 = 1'b1; run(b_pre3, b_main);

    // reset between preload and use: array contents must survive
    HRESETn = 1'b0;
    #1;
    check("rst0 hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    check("rst0 hresp",     32'(bus0.HRESP),     32'd0);
    check("rst0 hrdata",    bus0.HRDATA,         32'd0);
    check("rst3 hreadyout", 32'(bus3.HREADYOUT), 32'd1);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    use3 = 1'b0; run(b_main, b_d3);
    use3 = 1'b1; run(b_d3, b_post);

    // reset in the middle of a three-wait read, away from any clock edge
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 12'h020;
    @(posedge HCLK); #1;
    drive_idle();
    @(posedge HCLK); #1;
    check("midrst waiting", 32'(bus3.HREADYOUT), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst hreadyout", 32'(bus3.HREADYOUT), 32'd1);
    check("midrst hresp",     32'(bus3.HRESP),     32'd0);
    check("midrst hrdata",    bus3.HRDATA,         32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge HCLK); #1 HRESETn = 1'b1;

    run(b_post, b_end);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
